// File: rtl/vram_if.sv
// Video-RAM arbiter bundle: video fetch, CPU request/ack and single-port RAM signals.
// master = requesters plus RAM model side, slave = the arbiter.
interface vram_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vid_data, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vid_data, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch beats write-buffer drain beats CPU; VRAM_WRITE_BUFFER_EN adds a posted write buffer.
// Latency: video data 1 cycle after vid_req, always; CPU ack 1 cycle after its grant.
// Backpressure: video never stalls; the CPU request is held pending (no timeout) while video or a drain owns the slot.
module vram_arbiter #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic   clk,
    input  logic   reset_n,
    vram_if.slave  bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_vid_vld;
    logic [DW-1:0] r_vid_hold;
    logic [DW-1:0] r_rdata_hold;
    logic          r_cpu_ack;
    logic          r_ack_rd;

    logic          w_idle;
    logic          w_cpu_grant;
    logic          w_mem_we_raw;
    logic [DW-1:0] w_ack_rdata;

    assign w_idle = (r_state == S_IDLE);

`ifdef VRAM_WRITE_BUFFER_EN
    logic          r_buf_full;
    logic [AW-1:0] r_buf_addr;
    logic [DW-1:0] r_buf_data;
    logic          r_ack_hit;
    logic [DW-1:0] r_hit_data;

    logic          w_drain;
    logic          w_buf_take;
    logic          w_hit_rd;
    logic          w_ram_grant;

    // Drain takes any slot video leaves free; CPU reads never touch RAM while a write is posted.
    assign w_drain     = r_buf_full && !bus.vid_req;
    assign w_buf_take  = w_idle && bus.cpu_req && bus.cpu_we && !r_buf_full;
    assign w_hit_rd    = w_idle && bus.cpu_req && !bus.cpu_we && r_buf_full
                         && (bus.cpu_addr == r_buf_addr);
    assign w_ram_grant = w_idle && bus.cpu_req && !bus.cpu_we && !r_buf_full
                         && !bus.vid_req;
    assign w_cpu_grant = w_buf_take || w_hit_rd || w_ram_grant;

    assign w_mem_we_raw  = w_drain;
    assign bus.mem_addr  = bus.vid_req ? bus.vid_addr :
                           (w_drain ? r_buf_addr : bus.cpu_addr);
    assign bus.mem_wdata = w_drain ? r_buf_data : bus.cpu_wdata;
    assign w_ack_rdata   = r_ack_hit ? r_hit_data : bus.mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_full <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_ack_hit  <= 1'b0;
            r_hit_data <= '0;
        end else begin
            if (w_drain) begin
                r_buf_full <= 1'b0;
            end
            if (w_buf_take) begin
                r_buf_full <= 1'b1;
                r_buf_addr <= bus.cpu_addr;
                r_buf_data <= bus.cpu_wdata;
            end
            if (w_cpu_grant) begin
                r_ack_hit <= w_hit_rd;
            end
            // Snapshot the hit data now: the same cycle may drain and free the entry.
            if (w_hit_rd) begin
                r_hit_data <= r_buf_data;
            end
        end
    end
`else
    assign w_cpu_grant   = w_idle && bus.cpu_req && !bus.vid_req;
    assign w_mem_we_raw  = w_cpu_grant && bus.cpu_we;
    assign bus.mem_addr  = bus.vid_req ? bus.vid_addr : bus.cpu_addr;
    assign bus.mem_wdata = bus.cpu_wdata;
    assign w_ack_rdata   = bus.mem_rdata;
`endif

    // RAM write strobe is combinational, so it is forced low while reset is asserted.
    assign bus.mem_we    = reset_n && w_mem_we_raw;

    assign bus.vid_data  = r_vid_vld ? bus.mem_rdata : r_vid_hold;
    assign bus.cpu_rdata = (r_state == S_ACK && r_ack_rd) ? w_ack_rdata : r_rdata_hold;
    assign bus.cpu_ack   = r_cpu_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vid_vld <= 1'b0;
            r_vid_hold <= '0;
        end else begin
            r_vid_vld <= bus.vid_req;
            if (r_vid_vld) begin
                r_vid_hold <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cpu_ack    <= 1'b0;
            r_ack_rd     <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_grant) begin
                        r_state   <= S_ACK;
                        r_cpu_ack <= 1'b1;
                        r_ack_rd  <= !bus.cpu_we;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    if (r_ack_rd) begin
                        r_rdata_hold <= w_ack_rdata;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected acks and video bytes, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vram_if #(.AW(AW), .DW(DW)) vif ();

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (vif)
    );

    typedef struct {
        int            req_cyc;
        int            lat;
        bit            rd;
        logic [DW-1:0] data;
    } cpu_exp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } vid_exp_t;

    cpu_exp_t cpu_q[$];
    vid_exp_t vid_q[$];
    cpu_exp_t m_e;
    vid_exp_t m_v;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Unwritten RAM locations read as a fixed address pattern.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        if (a == 13'h0123) return 8'h5A;
        return a[7:0] ^ {3'b000, a[12:8]};
    endfunction

    bit [DW:0] ram [0:(1<<AW)-1];
    logic [DW:0] ram_rd;
    always @(posedge clk) begin
        ram_rd = ram[vif.mem_addr];
        if (vif.mem_we) ram[vif.mem_addr] <= {1'b1, vif.mem_wdata};
        vif.mem_rdata <= ram_rd[DW] ? ram_rd[DW-1:0] : pat(vif.mem_addr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (vif.cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check("ack_without_request", vif.cpu_ack, 1'b0);
                end else begin
                    m_e = cpu_q.pop_front();
                    if (m_e.lat > 0) check("cpu_ack_latency", cyc - m_e.req_cyc, m_e.lat);
                    else check("cpu_ack_latency_le3", ((cyc - m_e.req_cyc) <= 3), 1);
                    if (m_e.rd) check("cpu_rdata", vif.cpu_rdata, m_e.data);
                end
            end
            while (vid_q.size() > 0 && vid_q[0].cyc <= cyc) begin
                m_v = vid_q.pop_front();
                check("vid_data", vif.vid_data, m_v.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_start(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input int lat, input logic [DW-1:0] exp, input bit push);
        cpu_exp_t e;
        vif.cpu_req   = 1'b1;
        vif.cpu_we    = we;
        vif.cpu_addr  = a;
        vif.cpu_wdata = wd;
        e.req_cyc = cyc;
        e.lat     = lat;
        e.rd      = !we;
        e.data    = exp;
        if (push) cpu_q.push_back(e);
    endtask

    task automatic cpu_finish();
        int n = 0;
        tick();
        while (!vif.cpu_ack && n < 20) begin
            tick();
            n++;
        end
        if (!vif.cpu_ack) check("cpu_ack_timeout", vif.cpu_ack, 1'b1);
        tick();
        vif.cpu_req = 1'b0;
    endtask

    task automatic vid_start(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
        vid_exp_t v;
        vif.vid_req  = 1'b1;
        vif.vid_addr = a;
        for (int i = 0; i <= hold; i++) begin
            v.cyc  = cyc + 1 + i;
            v.data = exp;
            vid_q.push_back(v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        vif.vid_req = 0; vif.vid_addr = 0;
        vif.cpu_req = 0; vif.cpu_we = 0; vif.cpu_addr = 0; vif.cpu_wdata = 0;

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            tick();
            vif.cpu_req = 1'b1; vif.cpu_we = 1'b1;
            vif.vid_req = i[0]; vif.vid_addr = 13'h0123 + i[12:0];
            vif.cpu_addr = 13'h0F00 + i[12:0]; vif.cpu_wdata = 8'hC0 + i[7:0];
            #1;
            check("reset_mem_we", vif.mem_we, 1'b0);
            check("reset_cpu_ack", vif.cpu_ack, 1'b0);
            check("reset_vid_data", vif.vid_data, 8'h00);
        end
        check("reset_cpu_rdata", vif.cpu_rdata, 8'h00);
        vif.cpu_req = 0; vif.cpu_we = 0; vif.vid_req = 0;
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_vid_data", vif.vid_data, 8'h00);

        // Video fetch and hold
        vid_start(13'h0123, 8'h5A, 7);
        tick();
        vif.vid_req = 0;
        repeat (8) tick();

        // Uncontended write then read at the top address
        cpu_start(1'b1, 13'h1FFF, 8'hA5, 1, 8'h00, 1'b1);
        cpu_finish();
        cpu_start(1'b0, 13'h1FFF, 8'h00, 1, 8'hA5, 1'b1);
        cpu_finish();

        // Collision: video wins, CPU granted one cycle later
        cpu_start(1'b0, 13'h0040, 8'h00, 2, 8'h40, 1'b1);
        vid_start(13'h0041, 8'h41, 0);
        #1;
        check("collision_mem_addr_vid", vif.mem_addr, 13'h0041);
        check("collision_mem_we", vif.mem_we, 1'b0);
        tick();
        vif.vid_req = 0;
        #1;
        check("collision_mem_addr_cpu", vif.mem_addr, 13'h0040);
        cpu_finish();

        // Video request in the ACK cycle
        cpu_start(1'b0, 13'h0100, 8'h00, 1, 8'h01, 1'b1);
        tick();
        check("ack_cycle_cpu_ack", vif.cpu_ack, 1'b1);
        vid_start(13'h0102, 8'h03, 1);
        #1;
        check("ack_cycle_mem_addr", vif.mem_addr, 13'h0102);
        tick();
        vif.vid_req = 0;
        vif.cpu_req = 0;
        repeat (2) tick();

        // Two back-to-back video fetches push the CPU ack out by two cycles
        cpu_start(1'b0, 13'h0A00, 8'h00, 3, 8'h0A, 1'b1);
        vid_start(13'h0A01, 8'h0B, 0);
        tick();
        vid_start(13'h0A02, 8'h08, 1);
        tick();
        vif.vid_req = 0;
        cpu_finish();

        // Periodic video against continuous CPU reads
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    a = 13'h1000 + 13'(k * 3);
                    vid_start(a, pat(a), 7);
                    tick();
                    vif.vid_req = 0;
                    repeat (7) tick();
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    cpu_start(1'b0, 13'h0800 + 13'(i * 5), 8'h00, -1,
                              pat(13'h0800 + 13'(i * 5)), 1'b1);
                    cpu_finish();
                end
            end
        join

        // Reset in the grant cycle of a write: no ack, no RAM write, FSM back in IDLE
        tick();
        cpu_start(1'b1, 13'h0300, 8'hEE, 0, 8'h00, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_mem_we", vif.mem_we, 1'b0);
        tick();
        vif.cpu_req = 0;
        check("midreset_cpu_ack", vif.cpu_ack, 1'b0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midreset_no_ack", vif.cpu_ack, 1'b0);
        end
        cpu_start(1'b0, 13'h0300, 8'h00, 1, 8'h03, 1'b1);
        cpu_finish();

`ifdef VRAM_WRITE_BUFFER_EN
        // Posted write under video contention, read hit before the drain
        cpu_start(1'b1, 13'h0200, 8'h77, 1, 8'h00, 1'b1);
        vid_start(13'h0005, 8'h05, 0);
        tick();
        vid_start(13'h0006, 8'h06, 0);
        tick();
        cpu_start(1'b0, 13'h0200, 8'h00, 1, 8'h77, 1'b1);
        vid_start(13'h0007, 8'h07, 0);
        tick();
        vif.vid_req = 0;
        vif.cpu_req = 0;
        check("wbuf_not_drained_yet", ram[13'h0200], {1'b0, 8'h00});
        tick();
        check("wbuf_drained", ram[13'h0200], {1'b1, 8'h77});
        cpu_start(1'b0, 13'h0200, 8'h00, 1, 8'h77, 1'b1);
        cpu_finish();
`endif

        repeat (5) tick();
        check("cpu_queue_empty", cpu_q.size(), 0);
        check("vid_queue_empty", vid_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-RAM arbiter between the 8 KB shared display memory, the VGA scan-out fetch and the CPU bus. Video fetches are strictly highest priority and return data with fixed one-cycle latency, so the VGA generator can sample its byte on the phase following its request. CPU reads and writes use the remaining RAM cycles through a request/acknowledge handshake. The block runs entirely in the pixel-clock domain.

## Interface
Parameters:
- AW, 13, RAM address width (8 KB).
- DW, 8, RAM data width.

Ports:
- clk  in  1  pixel clock; only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video fetch strobe, single-cycle pulse.
- vid_addr  in  AW  video fetch address, valid while vid_req=1.
- vid_data  out  DW  fetched video byte.
- cpu_req  in  1  CPU access request, level; addr/we/wdata stable until acked.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_addr  out  AW  RAM address, combinational.
- mem_we  out  1  RAM write enable, combinational.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, synchronous, valid the cycle after the address.

## Operation
- The RAM performs one access per cycle. Slot owner is decided combinationally each cycle in this order:
  - vid_req.
  - Write-buffer drain (only when configured).
  - CPU access: only when the FSM is IDLE and cpu_req=1.
- Video slot:
  - mem_addr=vid_addr, mem_we=0.
  - Registered flag vid_valid_q=1 in the next cycle.
  - vid_data = vid_valid_q ? mem_rdata : vid_hold.
  - vid_hold loads mem_rdata whenever vid_valid_q=1, so vid_data stays stable between fetches.
- CPU FSM states:
  - IDLE: grant the CPU if it owns the slot, then go to ACK. Read: mem_we=0. Write: mem_we=1, mem_wdata=cpu_wdata. If video owns the slot, stay in IDLE; the CPU request stays pending with no timeout.
  - ACK: cpu_ack=1 (registered). For a read, cpu_rdata=mem_rdata and rdata_hold loads it; outside ACK, cpu_rdata=rdata_hold. No CPU grant in ACK. Return to IDLE unconditionally.
- The requester deasserts cpu_req or presents a new request in the cycle after ACK. Minimum CPU access period is 2 cycles.
- An idle RAM cycle drives mem_we=0 and mem_addr=cpu_addr.

## Timing
- Reset values: vid_data=0, cpu_rdata=0, cpu_ack=0, FSM=IDLE, vid_valid_q=0, holds=0, write buffer empty. mem_we=0 while reset_n=0.
- Video: vid_req at cycle N gives vid_data=RAM[vid_addr] during N+1 and held afterwards. Latency is always 1, regardless of CPU traffic.
- CPU uncontended: cpu_req at N, cpu_ack at N+1.
- Each vid_req coinciding with a pending grant delays cpu_ack by one cycle.
- vid_req in the ACK cycle: the video access is served; cpu_ack is unaffected.
- vid_req and cpu_req arriving together: video wins, CPU is granted at N+1 and acked at N+2.
- Reset asserted mid-access: the FSM returns to IDLE and no cpu_ack is issued for the aborted request.

## Configuration
- VRAM_WRITE_BUFFER_EN, when defined, adds a one-entry posted write buffer (addr, data, full flag).
- Writes with the buffer:
  - A write in IDLE with the buffer empty is captured into the buffer and acked at N+1, even under video contention.
  - The buffer drains into the first RAM slot not taken by video. The drain has priority over CPU grants.
  - A write arriving while the buffer is full waits in IDLE until the buffer drains.
- Reads with the buffer:
  - A read whose cpu_addr matches the full buffer's address returns the buffered data at ACK without a RAM access.
  - A read to any other address waits for the drain.
- Undefined: writes go directly to RAM as described in Operation.

## Test plan
- Reset: hold reset_n=0 and toggle all inputs -> cpu_ack=0, mem_we=0, vid_data=0; after release, vid_req at addr 0x0123 with RAM=0x5A -> vid_data=0x5A one cycle later and held for 7 cycles.
- Uncontended CPU: write 0xA5 to 0x1FFF, then read 0x1FFF -> cpu_ack at N+1 for each, cpu_rdata=0xA5.
- Collision: cpu_req(read 0x0040) and vid_req(0x0041) in the same cycle -> mem_addr=0x0041 first, cpu_ack at N+2 with RAM[0x0040].
- Periodic video: vid_req every 8 cycles, continuous CPU reads -> every vid_data correct at latency 1, no cpu_ack lost, cpu_req→cpu_ack ≤3 cycles.
- Mid-access reset: cpu_req write asserted, reset_n pulsed low in the grant cycle -> no cpu_ack, FSM in IDLE after release.
- VRAM_WRITE_BUFFER_EN: write 0x77 to 0x0200 during vid_req, then read 0x0200 -> write ack at N+1, read returns 0x77 before the drain; RAM holds 0x77 after the next free slot.
